piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parallel-in serial-out serializer that sits directly upstream of the team's serial-in parallel-out shift register. It accepts a WIDTH-bit word over a valid/ready handshake and drives it onto a single serial line, one bit per clk cycle. It also flags valid and last-bit, so the downstream register can capture a complete word. Back-to-back words stream with no idle gap.

Parameters:
WIDTH, 4, word width in bits (>= 2).
MSB_FIRST, 1, 1 = bit WIDTH-1 is transmitted first; 0 = bit 0 is transmitted first.

Ports:
clk  input  1  rising-edge clock; the single clock domain.
rst  input  1  synchronous, active-high reset.
load_valid  input  1  upstream has a word on load_data.
load_data  input  WIDTH  parallel word; sampled only on an accept edge.
load_ready  output  1  serializer can accept a word this cycle.
sout  output  1  serial data; drives the downstream d input.
sout_valid  output  1  sout carries a valid data bit this cycle.
frame_last  output  1  high only while the last bit of a word is on sout.
busy  output  1  high while a word is being shifted out (equals sout_valid).

Behaviour:
- Reset: rst is sampled on the clk rising edge only. When asserted, the next state is:
  - state = IDLE, bit counter = 0, shift register = 0.
  - sout = 0, sout_valid = 0, frame_last = 0, busy = 0.
  - load_ready = 1 in the first cycle after reset deasserts.
- Reset mid-frame aborts the word immediately. No remaining bits are emitted, and the aborted word is not replayed.
- State machine: two states, IDLE and SHIFT.
  - IDLE: load_ready = 1; sout = 0; sout_valid = 0.
  - IDLE -> SHIFT: on an edge with load_valid && load_ready.
    - load_data is captured into the shift register and the counter is set to 0.
  - SHIFT: sout_valid = 1; the counter increments once per cycle, from 0 to WIDTH-1.
  - frame_last = 1 exactly when counter == WIDTH-1.
- load_ready rule: load_ready = (state == IDLE) || (state == SHIFT && counter == WIDTH-1). It is combinational from registered state only and never depends on load_valid.
- Accept on the last bit: state stays SHIFT, new data is loaded, and the counter resets to 0. The first bit of the new word appears in the very next cycle, giving zero bubble.
- Last bit with no accept: SHIFT -> IDLE, and sout returns to 0 the next cycle.
- load_valid while load_ready = 0 is ignored. Data is not captured; upstream must hold load_valid and load_data until it sees ready.
- Latency: a word accepted at edge N puts its first bit on sout during the cycle after edge N. A word occupies exactly WIDTH consecutive cycles on sout.
- Bit order:
  - MSB_FIRST = 1: bit index k (k = 0..WIDTH-1) of the frame is load_data[WIDTH-1-k].
  - MSB_FIRST = 0: bit index k is load_data[k].
- Register outputs: sout, sout_valid, frame_last and busy are all registered, with no combinational path from the inputs. The shift register shifts in 0 at the vacated end.
- Downstream contract: with MSB_FIRST = 1, a 4-bit shift register that shifts toward its MSB holds the original word on the edge that consumes the frame_last bit.

Test Plan:
- WIDTH=4, MSB_FIRST=1; after reset, load 4'b1011 for one cycle.
  - Next 4 cycles: sout = 1,0,1,1 with sout_valid = 1; frame_last = 1 only on the 4th; load_ready = 0 on cycles 1-3.
  - Then sout = 0 and sout_valid = 0.
- Back-to-back: 4'hA accepted, then 4'h5 held valid and accepted on 4'hA's last bit.
  - Required: 8 contiguous bits 1,0,1,0,0,1,0,1 with sout_valid high for 8 cycles and no gap.
  - frame_last high on bits 4 and 8.
- Busy rejection: during 4'hA's 2nd bit, assert load_valid with 4'hF.
  - Required: it is not captured until the last-bit cycle; the 4'hA output is unchanged; 4'hF follows immediately after.
- Reset mid-frame: load 4'b1101 and assert rst during bit 2.
  - Required: the next cycle has sout = 0, sout_valid = 0, load_ready = 1, and no further bits.
  - A subsequent 4'b0110 serializes cleanly as 0,1,1,0.
- MSB_FIRST=0: load 4'b1011.
  - Required: sout = 1,1,0,1.
- WIDTH=8, MSB_FIRST=1: load 8'hA5.
  - Required: sout = 1,0,1,0,0,1,0,1 over 8 cycles, frame_last on the 8th.
  - Also end-to-end: feed a 4-bit SIPO and check it reads back the loaded word on frame_last.

Source files
------------

// File: rtl/piso_serializer.sv
// piso_serializer
// Parallel-in serial-out serializer feeding a downstream SIPO shift register.
// A WIDTH-bit word is accepted over a valid/ready handshake and emitted on
// sout, one bit per clk cycle. Back-to-back words stream with no idle gap.
//
// Parameters:
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 leaves first; 0: bit 0 leaves first
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   load_valid  upstream has a word on load_data
//   load_data   parallel word, sampled only on an accept edge
//   load_ready  serializer can accept a word this cycle
//   sout        serial data bit (registered)
//   sout_valid  sout carries a valid data bit this cycle
//   frame_last  high while the last bit of a word is on sout
//   busy        high while a word is being shifted out (same as sout_valid)
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_last,
    output logic             busy
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               sout_q, sout_d;
    logic               last_q, last_d;
    logic               at_last;
    logic               accept;

    // Bit that leaves first from a word, per the configured bit order.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Word with its leading bit removed; a 0 fills the vacated end.
    function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign at_last    = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    // Ready depends only on registered state, never on load_valid.
    assign load_ready = (state_q == IDLE) || at_last;
    assign accept     = load_valid && load_ready;

    // sout holds the bit currently on the line; shreg holds the bits still
    // to come, so the first bit is visible the cycle right after the accept.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        sout_d  = sout_q;
        last_d  = last_q;
        if (accept) begin
            // Also covers the accept on the last bit: zero-bubble reload.
            state_d = SHIFT;
            cnt_d   = '0;
            shreg_d = drop_head(load_data);
            sout_d  = head_bit(load_data);
            last_d  = 1'b0;
        end else if (state_q == SHIFT) begin
            if (at_last) begin
                state_d = IDLE;
                cnt_d   = '0;
                shreg_d = '0;
                sout_d  = 1'b0;
                last_d  = 1'b0;
            end else begin
                cnt_d   = cnt_q + CNT_ONE;
                shreg_d = drop_head(shreg_q);
                sout_d  = head_bit(shreg_q);
                last_d  = ((cnt_q + CNT_ONE) == LAST_CNT);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            sout_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            sout_q  <= sout_d;
            last_q  <= last_d;
        end
    end

    assign sout       = sout_q;
    assign sout_valid = (state_q == SHIFT);
    assign busy       = (state_q == SHIFT);
    assign frame_last = last_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three configurations (W4 MSB-first, W4
// LSB-first, W8 MSB-first) share one stimulus stream. A word-level model
// predicts every output on every cycle, a downstream SIPO rebuilds each word
// at frame_last, and directed scenarios pin the model with literal values.
module tb_piso_serializer;

    logic       clk;
    logic       rst;
    logic       lv;
    logic [7:0] ld;

    logic o_sout [3];
    logic o_vld  [3];
    logic o_last [3];
    logic o_rdy  [3];
    logic o_busy [3];

    int n_cmp = 0;
    int n_err = 0;
    bit armed = 1'b0;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_w4_msb (
        .clk(clk), .rst(rst), .load_valid(lv), .load_data(ld[3:0]),
        .load_ready(o_rdy[0]), .sout(o_sout[0]), .sout_valid(o_vld[0]),
        .frame_last(o_last[0]), .busy(o_busy[0]));

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_w4_lsb (
        .clk(clk), .rst(rst), .load_valid(lv), .load_data(ld[3:0]),
        .load_ready(o_rdy[1]), .sout(o_sout[1]), .sout_valid(o_vld[1]),
        .frame_last(o_last[1]), .busy(o_busy[1]));

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_w8_msb (
        .clk(clk), .rst(rst), .load_valid(lv), .load_data(ld),
        .load_ready(o_rdy[2]), .sout(o_sout[2]), .sout_valid(o_vld[2]),
        .frame_last(o_last[2]), .busy(o_busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wid(input int i);
        return (i == 2) ? 8 : 4;
    endfunction

    function automatic bit msb(input int i);
        return (i != 1);
    endfunction

    function automatic logic [7:0] wmask(input int i);
        return (i == 2) ? 8'hFF : 8'h0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Word-level model: which word is on the line and which bit index of
    // its frame is showing (-1 when idle).
    int         pos   [3] = '{-1, -1, -1};
    logic [7:0] mword [3] = '{8'h00, 8'h00, 8'h00};
    logic [7:0] acc   [3] = '{8'h00, 8'h00, 8'h00};

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst)
                pos[i] <= -1;
            else if (lv && (pos[i] < 0 || pos[i] == wid(i) - 1)) begin
                pos[i]   <= 0;
                mword[i] <= ld & wmask(i);
            end else if (pos[i] >= 0)
                pos[i] <= (pos[i] == wid(i) - 1) ? -1 : pos[i] + 1;
        end
    end

    function automatic logic exp_bit(input int i, input int p, input logic [7:0] w);
        if (p < 0) return 1'b0;
        return msb(i) ? w[wid(i) - 1 - p] : w[p];
    endfunction

    // Downstream SIPO: MSB-first shifts toward its MSB, LSB-first toward its LSB.
    function automatic logic [7:0] shin(input int i, input logic [7:0] a, input logic b);
        return msb(i) ? {a[6:0], b} : {b, a[7:1]};
    endfunction

    function automatic logic [7:0] recon(input int i, input logic [7:0] a);
        if (msb(i)) return a & wmask(i);
        return (wid(i) == 8) ? a : {4'h0, a[7:4]};
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("sout[%0d]", i), {31'b0, o_sout[i]}, {31'b0, exp_bit(i, pos[i], mword[i])});
                chk($sformatf("sout_valid[%0d]", i), {31'b0, o_vld[i]}, {31'b0, (pos[i] >= 0)});
                chk($sformatf("busy[%0d]", i), {31'b0, o_busy[i]}, {31'b0, (pos[i] >= 0)});
                chk($sformatf("frame_last[%0d]", i), {31'b0, o_last[i]}, {31'b0, (pos[i] == wid(i) - 1)});
                chk($sformatf("load_ready[%0d]", i), {31'b0, o_rdy[i]},
                    {31'b0, (pos[i] < 0 || pos[i] == wid(i) - 1)});
                if (o_vld[i] === 1'b1) begin
                    acc[i] <= shin(i, acc[i], o_sout[i]);
                    if (o_last[i] === 1'b1)
                        chk($sformatf("sipo_word[%0d]", i),
                            {24'b0, recon(i, shin(i, acc[i], o_sout[i]))}, {24'b0, mword[i]});
                end
            end
        end
    end

    // Load word a; b is presented either back-to-back (start_k < 0) or from
    // after sample start_k. Collects 8 cycles of the W4 MSB-first output.
    task automatic run_pair(input logic [3:0] a, input logic [3:0] b, input int start_k,
                            output logic [7:0] got, output logic [7:0] lastm, output int nv);
        nv = 0;
        lv = 1'b1;
        ld = {4'h0, a};
        tick;
        lv = (start_k < 0);
        ld = {4'h0, b};
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            got[7-k]   = o_sout[0];
            lastm[7-k] = o_last[0];
            if (o_vld[0] === 1'b1) nv++;
            tick;
            if (k == start_k) lv = 1'b1;
            if (k == 3) lv = 1'b0;
        end
    endtask

    logic [7:0] got8, lastm8, e8;
    logic [3:0] e4a, e4b;
    int         nv;

    initial begin
        rst = 1'b1;
        lv  = 1'b0;
        ld  = 8'h00;
        repeat (2) tick;
        rst   = 1'b0;
        armed = 1'b1;

        @(negedge clk);
        chk("reset_ready", {31'b0, o_rdy[0]}, 32'd1);
        chk("reset_sout", {31'b0, o_sout[0]}, 32'd0);
        chk("reset_valid", {31'b0, o_vld[0]}, 32'd0);
        chk("reset_last", {31'b0, o_last[0]}, 32'd0);

        // 4'b1011: MSB-first 1,0,1,1 and LSB-first 1,1,0,1
        tick;
        lv  = 1'b1;
        ld  = 8'h0B;
        tick;
        lv  = 1'b0;
        e4a = 4'b1011;
        e4b = 4'b1101;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("w1011_msb_bit", {31'b0, o_sout[0]}, {31'b0, e4a[3-k]});
            chk("w1011_lsb_bit", {31'b0, o_sout[1]}, {31'b0, e4b[3-k]});
            chk("w1011_last", {31'b0, o_last[0]}, {31'b0, (k == 3)});
            chk("w1011_ready", {31'b0, o_rdy[0]}, {31'b0, (k == 3)});
        end
        @(negedge clk);
        chk("w1011_idle_valid", {31'b0, o_vld[0]}, 32'd0);
        chk("w1011_idle_sout", {31'b0, o_sout[0]}, 32'd0);
        repeat (8) tick;

        // back-to-back 4'hA then 4'h5
        run_pair(4'hA, 4'h5, -1, got8, lastm8, nv);
        chk("b2b_bits", {24'b0, got8}, 32'hA5);
        chk("b2b_last", {24'b0, lastm8}, 32'h11);
        chk("b2b_valid_cycles", nv, 32'd8);
        repeat (10) tick;

        // 4'hF offered during 4'hA's second bit waits for the last-bit cycle
        run_pair(4'hA, 4'hF, 0, got8, lastm8, nv);
        chk("reject_bits", {24'b0, got8}, 32'hAF);
        chk("reject_last", {24'b0, lastm8}, 32'h11);
        chk("reject_valid_cycles", nv, 32'd8);
        repeat (10) tick;

        // reset in the middle of 4'b1101
        lv = 1'b1;
        ld = 8'h0D;
        tick;
        lv = 1'b0;
        @(negedge clk);
        chk("abort_bit0", {31'b0, o_sout[0]}, 32'd1);
        tick;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_bit1", {31'b0, o_sout[0]}, 32'd1);
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_sout", {31'b0, o_sout[0]}, 32'd0);
        chk("abort_valid", {31'b0, o_vld[0]}, 32'd0);
        chk("abort_ready", {31'b0, o_rdy[0]}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_no_bits", {31'b0, o_vld[0]}, 32'd0);
        end
        tick;
        lv  = 1'b1;
        ld  = 8'h06;
        tick;
        lv  = 1'b0;
        e4a = 4'b0110;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("after_abort_bit", {31'b0, o_sout[0]}, {31'b0, e4a[3-k]});
            chk("after_abort_valid", {31'b0, o_vld[0]}, 32'd1);
        end
        repeat (10) tick;

        // WIDTH=8: 8'hA5 -> 1,0,1,0,0,1,0,1
        lv = 1'b1;
        ld = 8'hA5;
        tick;
        lv = 1'b0;
        e8 = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("w8_bit", {31'b0, o_sout[2]}, {31'b0, e8[7-k]});
            chk("w8_last", {31'b0, o_last[2]}, {31'b0, (k == 7)});
        end
        repeat (4) tick;

        // randomized traffic with occasional resets
        repeat (600) begin
            rst = ($urandom_range(0, 39) == 0);
            lv  = ($urandom_range(0, 2) != 0);
            ld  = 8'($urandom);
            tick;
        end
        rst = 1'b0;
        lv  = 1'b0;
        repeat (12) tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
